// File: rtl/axis_frame_transmitter_if.sv
// axis_frame_transmitter_if: AXI4-Stream master bus carrying framed pixels to a VDMA/DMA.
//   tdata  : {8'd0, R, G, B}
//   tvalid : head entry present
//   tready : downstream accept
//   tlast  : last pixel of a line
//   tuser  : first pixel of a frame
interface axis_frame_transmitter_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_transmitter.sv
// axis_frame_transmitter: buffers the recovered RGB stream in a FWFT FIFO and re-frames it
// onto an AXI4-Stream master with TLAST per line and TUSER at start of frame.
//   ACLK, ARESETn  : clock, synchronous active-low reset
//   pix_data/valid : upstream pixels {R,G,B}; pix_ready is advisory (overrun by <= AF_MARGIN)
//   clear_overflow : clears the sticky overflow flag (a drop in the same cycle wins)
//   m_axis         : AXI4-Stream master with full backpressure
//   frame_done     : one-cycle pulse after the last pixel of a frame transfers
//   overflow       : sticky, set when a pixel arrives while the FIFO is full
module axis_frame_transmitter #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [23:0]                       pix_data,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    input  logic                              clear_overflow,
    axis_frame_transmitter_if.master          m_axis,
    output logic                              frame_done,
    output logic                              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = IMG_WIDTH  > 1 ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;

    // entry layout: [26]=sof, [25]=eol, [24]=eof, [23:0]=pixel
    logic [26:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          pix_ready_q, pix_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic          full, push, pop, sof, eol, eof, valid;
    logic [26:0]   head, wr_entry;

    always_comb begin
        full         = count_q == (AW+1)'(FIFO_DEPTH);
        valid        = count_q != '0;
        // full is judged on the registered count, so a same-cycle pop never frees a slot
        push         = pix_valid && !full;
        pop          = valid && m_axis.tready;
        head         = mem_q[rd_ptr_q];
        sof          = col_q == '0 && row_q == '0;
        eol          = col_q == CW'(IMG_WIDTH - 1);
        eof          = eol && row_q == RW'(IMG_HEIGHT - 1);
        wr_entry     = {sof, eol, eof, pix_data};
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        col_d        = push ? (eol ? '0 : col_q + CW'(1)) : col_q;
        row_d        = (push && eol) ? (eof ? '0 : row_q + RW'(1)) : row_q;
        overflow_d   = (pix_valid && full) ? 1'b1 : clear_overflow ? 1'b0 : overflow_q;
        // registering f(count_d) yields the same value as f(count_q) without a comb path
        pix_ready_d  = count_d <= (AW+1)'(FIFO_DEPTH - AF_MARGIN);
        frame_done_d = pop && head[24];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_ready_q  <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_ready_q  <= pix_ready_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // storage needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign m_axis.tvalid = valid;
    assign m_axis.tdata  = valid ? {8'd0, head[23:0]} : '0;
    assign m_axis.tlast  = valid && head[25];
    assign m_axis.tuser  = valid && head[26];
    assign pix_ready     = pix_ready_q;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
endmodule

// File: doc/axis_frame_transmitter.md
# axis_frame_transmitter

Output-side AXI4-Stream master for the haze-removal pipeline. It accepts the recovered RGB pixel stream from the TE/SRSC stage and buffers it in a small FIFO. It re-frames the stream with line (TLAST) and start-of-frame (TUSER) markers and presents it to a downstream AXI4-Stream slave (VDMA/DMA) with full TREADY backpressure. Upstream sees a conservative ready, so pixels in flight survive a downstream stall.

## Interface
- IMG_WIDTH, 512, pixels per line (≥2)
- IMG_HEIGHT, 512, lines per frame (≥1)
- FIFO_DEPTH, 16, entries, power of two, ≥8
- AF_MARGIN, 4, free entries kept when pix_ready deasserts (covers upstream pipeline drain)

- ACLK  in  1  single clock; all logic on rising edge
- ARESETn  in  1  synchronous reset, active-low
- pix_data  in  24  {R,G,B} from scene recovery
- pix_valid  in  1  pixel qualifier
- pix_ready  out  1  upstream may issue pixels; advisory, upstream may overrun by ≤AF_MARGIN
- clear_overflow  in  1  clears overflow flag
- M_AXIS_TDATA  out  32  {8'd0, R, G, B}
- M_AXIS_TVALID  out  1  FIFO non-empty
- M_AXIS_TREADY  in  1  downstream accept
- M_AXIS_TLAST  out  1  last pixel of a line
- M_AXIS_TUSER  out  1  first pixel of a frame
- frame_done  out  1  one-cycle pulse when last pixel of frame transfers
- overflow  out  1  sticky; pixel dropped because FIFO full

## Operation
- FIFO entry = {sof, eol, eof, pix_data} (27 bits).
- Write side: push when pix_valid && count < FIFO_DEPTH (count is registered; no same-cycle credit from a pop).
- Write-side counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on an accepted push.
  - sof = (col==0 && row==0)
  - eol = (col==IMG_WIDTH-1)
  - eof = eol && (row==IMG_HEIGHT-1)
  - col wraps to 0 at eol, and row increments at the same time.
  - row wraps to 0 at eof.
- Drop: pix_valid && count==FIFO_DEPTH → pixel discarded, counters unchanged, overflow←1.
- overflow clears on clear_overflow=1 unless a drop occurs in the same cycle (set wins).
- pix_ready = (count ≤ FIFO_DEPTH − AF_MARGIN), registered from count.
- Read side is first-word-fall-through.
  - M_AXIS_TVALID = (count≠0).
  - TDATA, TLAST and TUSER come from the head entry: TLAST=eol, TUSER=sof.
  - Pop on TVALID && TREADY.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count between 1 and FIFO_DEPTH−1. At count==FIFO_DEPTH, the push is dropped and the pop proceeds.
- frame_done is registered: it asserts the cycle after a pop whose head entry has eof=1.
- TDATA, TLAST and TUSER stay stable while TVALID && !TREADY. TVALID never deasserts without a transfer.
- Pointers wrap modulo FIFO_DEPTH. count width is log2(FIFO_DEPTH)+1.

## Timing
- Reset (ARESETn=0 at a clock edge):
  - pointers, count, col, row = 0
  - M_AXIS_TVALID=0, TLAST=0, TUSER=0, TDATA=0
  - pix_ready=1, frame_done=0, overflow=0
- Reset mid-frame discards FIFO contents and restarts framing at col=0,row=0. No partial-frame flush.
- Latency: a push into an empty FIFO at edge N gives TVALID=1 with that data after edge N. The first cycle TVALID can be high is N+1.
- Throughput: one pixel per cycle sustained while TREADY=1.
- pix_ready reflects count after the previous edge (one-cycle lag), which AF_MARGIN absorbs.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, TREADY=1, push 8 pixels 0x000001..0x000008 back-to-back:
  - output matches input order, one per cycle, first at cycle 1
  - TUSER only on 0x000001; TLAST on 0x000004 and 0x000008
  - frame_done pulses once, the cycle after 0x000008 transfers
- Same setup, 16 pixels (two frames): TUSER on pixels 1 and 9, frame_done pulses twice. Confirms row/col wrap.
- FIFO_DEPTH=16, AF_MARGIN=4, TREADY=0, push 20 pixels ignoring pix_ready:
  - pix_ready low once count reaches 13
  - 16 stored, 4 dropped, overflow=1
  - after TREADY=1, exactly 16 pixels emerge and framing skips the dropped pixels (no col advance)
- With TVALID=1, toggle TREADY randomly for 50 cycles: TDATA, TLAST and TUSER hold while stalled, and no beat is lost or duplicated.
- FIFO full with simultaneous pix_valid and TREADY: pop occurs, push dropped, overflow set. Then clear_overflow=1 with no drop clears it. clear_overflow together with a drop leaves it at 1.
- Assert ARESETn=0 after 5 pixels of a frame: all outputs return to reset values next edge. The next pixel pushed carries TUSER=1.
